// File: rtl/cpu_stall.sv
// -----------------------------------------------------------------------------
// cpu_stall
//
// Single-issue CPU core. Every non-memory instruction retires in one cycle.
// Loads and stores leave EXEC for MEM_WAIT and stay there until the data
// memory drops MEM_BUSYWAIT. The memory request (strobe, address, store data,
// load destination) is captured on entry to MEM_WAIT, so the request holds
// steady however long the memory stalls.
//
// Optional feature:
//   CPU_STALL_MULT_EN - when defined, opcode 0x0D (mult) writes the low
//                       DATA_W bits of rs1*rs2 to dest. When undefined, 0x0D
//                       is treated like any other undefined opcode (NOP).
//
// Parameters:
//   DATA_W      datapath / register width (8..32)
//   REG_ADDR_W  register index width (2**REG_ADDR_W registers)
//
// Ports:
//   CLK            rising-edge clock
//   RESET          synchronous, active-high reset
//   PC             address of the current instruction
//   INSTRUCTION    instruction at PC (combinational from PC)
//   MEM_READ       data-memory read strobe
//   MEM_WRITE      data-memory write strobe
//   MEM_ADDRESS    data-memory address
//   MEM_WRITEDATA  store data
//   MEM_READDATA   load data, valid while MEM_BUSYWAIT is low
//   MEM_BUSYWAIT   high while the memory access is still in progress
// -----------------------------------------------------------------------------
module cpu_stall #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [31:0]       PC,
    input  logic [31:0]       INSTRUCTION,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [DATA_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    localparam int         NUM_REGS = 1 << REG_ADDR_W;
    localparam logic [7:0] DW8      = 8'(DATA_W);

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_ROR   = 8'h09;
    localparam logic [7:0] OP_SLL   = 8'h0A;
    localparam logic [7:0] OP_SRL   = 8'h0B;
    localparam logic [7:0] OP_SRA   = 8'h0C;
`ifdef CPU_STALL_MULT_EN
    localparam logic [7:0] OP_MULT  = 8'h0D;
`endif
    localparam logic [7:0] OP_LWD   = 8'h0E;
    localparam logic [7:0] OP_LWI   = 8'h0F;
    localparam logic [7:0] OP_SWD   = 8'h10;
    localparam logic [7:0] OP_SWI   = 8'h11;

    typedef enum logic {
        EXEC     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // ---------------- state ----------------
    state_t                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];

    // Memory request captured when leaving EXEC
    logic [DATA_W-1:0]     mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                  mem_load_q,  mem_load_d;
    logic                  mem_store_q, mem_store_d;
    logic [REG_ADDR_W-1:0] mem_dest_q,  mem_dest_d;

    // Register-file write port (one write per cycle at most)
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;

    // ---------------- decode ----------------
    logic [7:0]            opcode, offset, imm8;
    logic [REG_ADDR_W-1:0] dest_idx, rs1_idx, rs2_idx;
    logic [DATA_W-1:0]     rs1_val, rs2_val, imm_val;

    assign opcode   = INSTRUCTION[31:24];
    assign offset   = INSTRUCTION[23:16];
    assign imm8     = INSTRUCTION[7:0];
    assign dest_idx = INSTRUCTION[16 +: REG_ADDR_W];
    assign rs1_idx  = INSTRUCTION[8  +: REG_ADDR_W];
    assign rs2_idx  = INSTRUCTION[0  +: REG_ADDR_W];
    assign rs1_val  = regs_q[rs1_idx];
    assign rs2_val  = regs_q[rs2_idx];
    assign imm_val  = DATA_W'(imm8);

    // Upper bits of the rs1 field carry no meaning for a small register file.
    generate
        if (REG_ADDR_W < 8) begin : g_rs1_pad
            logic unused_rs1_hi;
            assign unused_rs1_hi = ^INSTRUCTION[15:8+REG_ADDR_W];
        end
    endgenerate

    // ---------------- next-PC candidates ----------------
    logic [31:0] pc_plus4, branch_target;
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};

    // ---------------- shifter ----------------
    // The arithmetic shift is kept in its own signed net: folding it into a
    // ternary with an unsigned arm would silently turn it into a logical shift.
    logic signed [DATA_W-1:0] sra_raw;
    logic [7:0]               rot_amt;
    logic [DATA_W-1:0]        ror_res;

    assign sra_raw = $signed(rs1_val) >>> imm8;
    assign rot_amt = imm8 % DW8;
    // A shift by the full width yields zero, so rot_amt==0 needs no special case.
    assign ror_res = (rs1_val >> rot_amt) | (rs1_val << (DW8 - rot_amt));

    // ---------------- EXEC-stage decode ----------------
    logic              exec_we;
    logic [DATA_W-1:0] exec_wdata;
    logic [31:0]       exec_pc;
    logic              exec_load, exec_store;
    logic [DATA_W-1:0] exec_addr;

    always_comb begin
        exec_we    = 1'b0;
        exec_wdata = '0;
        exec_pc    = pc_plus4;
        exec_load  = 1'b0;
        exec_store = 1'b0;
        exec_addr  = rs2_val;
        case (opcode)
            OP_LOADI: begin exec_we = 1'b1; exec_wdata = imm_val;           end
            // mov copies rs1
            OP_MOV:   begin exec_we = 1'b1; exec_wdata = rs1_val;           end
            OP_ADD:   begin exec_we = 1'b1; exec_wdata = rs1_val + rs2_val; end
            OP_SUB:   begin exec_we = 1'b1; exec_wdata = rs1_val - rs2_val; end
            OP_AND:   begin exec_we = 1'b1; exec_wdata = rs1_val & rs2_val; end
            OP_OR:    begin exec_we = 1'b1; exec_wdata = rs1_val | rs2_val; end
            OP_J:     exec_pc = branch_target;
            OP_BEQ:   if (rs1_val == rs2_val) exec_pc = branch_target;
            OP_BNE:   if (rs1_val != rs2_val) exec_pc = branch_target;
            OP_ROR:   begin exec_we = 1'b1; exec_wdata = ror_res; end
            OP_SLL:   begin
                exec_we    = 1'b1;
                exec_wdata = (imm8 >= DW8) ? '0 : (rs1_val << imm8);
            end
            OP_SRL:   begin
                exec_we    = 1'b1;
                exec_wdata = (imm8 >= DW8) ? '0 : (rs1_val >> imm8);
            end
            OP_SRA:   begin
                exec_we    = 1'b1;
                exec_wdata = (imm8 >= DW8) ? {DATA_W{rs1_val[DATA_W-1]}}
                                           : DATA_W'(sra_raw);
            end
`ifdef CPU_STALL_MULT_EN
            OP_MULT:  begin exec_we = 1'b1; exec_wdata = rs1_val * rs2_val; end
`endif
            OP_LWD:   begin exec_load  = 1'b1; exec_addr = rs2_val; end
            OP_LWI:   begin exec_load  = 1'b1; exec_addr = imm_val; end
            OP_SWD:   begin exec_store = 1'b1; exec_addr = rs2_val; end
            OP_SWI:   begin exec_store = 1'b1; exec_addr = imm_val; end
            default:  ; // undefined opcode: plain PC+4, no write
        endcase
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rf_we       = 1'b0;
        rf_waddr    = dest_idx;
        rf_wdata    = exec_wdata;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_load_d  = mem_load_q;
        mem_store_d = mem_store_q;
        mem_dest_d  = mem_dest_q;
        case (state_q)
            EXEC: begin
                if (exec_load || exec_store) begin
                    // PC holds; the request is frozen for the wait phase
                    state_d     = MEM_WAIT;
                    mem_addr_d  = exec_addr;
                    mem_wdata_d = rs1_val;
                    mem_load_d  = exec_load;
                    mem_store_d = exec_store;
                    mem_dest_d  = dest_idx;
                end else begin
                    rf_we = exec_we;
                    pc_d  = exec_pc;
                end
            end
            MEM_WAIT: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = EXEC;
                    pc_d    = pc_plus4;
                    if (mem_load_q) begin
                        rf_we    = 1'b1;
                        rf_waddr = mem_dest_q;
                        rf_wdata = MEM_READDATA;
                    end
                end
            end
        endcase
    end

    // ---------------- sequential state ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= EXEC;
            pc_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_load_q  <= 1'b0;
            mem_store_q <= 1'b0;
            mem_dest_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_load_q  <= mem_load_d;
            mem_store_q <= mem_store_d;
            mem_dest_q  <= mem_dest_d;
            if (rf_we) begin
                regs_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    // ---------------- outputs ----------------
    assign PC = pc_q;

    // Strobes are combinational so the memory sees the request in the issuing
    // cycle, and drop in the completing cycle. RESET masks them immediately,
    // which also abandons an in-flight access.
    always_comb begin
        MEM_ADDRESS   = exec_addr;
        MEM_WRITEDATA = rs1_val;
        MEM_READ      = exec_load;
        MEM_WRITE     = exec_store;
        if (state_q == MEM_WAIT) begin
            MEM_ADDRESS   = mem_addr_q;
            MEM_WRITEDATA = mem_wdata_q;
            MEM_READ      = mem_load_q  & MEM_BUSYWAIT;
            MEM_WRITE     = mem_store_q & MEM_BUSYWAIT;
        end
        if (RESET) begin
            MEM_READ  = 1'b0;
            MEM_WRITE = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_stall.sv
// -----------------------------------------------------------------------------
// tb_cpu_stall - directed self-checking bench for cpu_stall (DATA_W=8,
// REG_ADDR_W=3). Instructions are driven straight onto INSTRUCTION; register
// contents are observed through a swi, whose MEM_WRITEDATA carries rs1.
// -----------------------------------------------------------------------------
module tb_cpu_stall;

    logic        CLK;
    logic        RESET;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [7:0]  MEM_ADDRESS;
    logic [7:0]  MEM_WRITEDATA;
    logic [7:0]  MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int          total    = 0;
    int          passed   = 0;
    int          fail_cnt = 0;
    logic [31:0] exp_pc;
    logic [31:0] pc0;

    cpu_stall #(.DATA_W(8), .REG_ADDR_W(3)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PC            (PC),
        .INSTRUCTION   (INSTRUCTION),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] d,
                                        input logic [7:0] a, input logic [7:0] b);
        return {op, d, a, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (failure #%0d)", tag, obs, exp, fail_cnt);
        end
        $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Execute one single-cycle instruction and check the resulting PC.
    task automatic run(input logic [31:0] ins, input logic [31:0] nxt, input string tag);
        INSTRUCTION = ins;
        @(posedge CLK); #1;
        exp_pc = nxt;
        check({tag, "_pc"}, PC, exp_pc);
    endtask

    // Read a register by issuing swi rX,0x3C with no memory stall.
    task automatic read_reg(input logic [7:0] idx, input logic [7:0] exp, input string tag);
        INSTRUCTION  = enc(8'h11, 8'h00, idx, 8'h3C);
        MEM_BUSYWAIT = 1'b0;
        #1;
        check({tag, "_wr"}, MEM_WRITE, 1);
        check(tag, MEM_WRITEDATA, exp);
        @(posedge CLK); #1;
        check({tag, "_wrdone"}, MEM_WRITE, 0);
        @(posedge CLK); #1;
        exp_pc = exp_pc + 32'd4;
        check({tag, "_pc"}, PC, exp_pc);
    endtask

    initial begin
        // ---------------- reset ----------------
        RESET        = 1'b1;
        INSTRUCTION  = enc(8'h0F, 8'h05, 8'h00, 8'h20);   // lwi held during reset
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pc", PC, 0);
        check("rst_rd", MEM_READ, 0);
        INSTRUCTION = enc(8'h11, 8'h00, 8'h01, 8'h10);    // swi held during reset
        #1;
        check("rst_wr", MEM_WRITE, 0);
        RESET  = 1'b0;
        exp_pc = 0;

        // ---------------- basic ALU ----------------
        run(enc(8'h00, 8'h01, 8'h00, 8'h05), exp_pc + 4, "loadi_r1");
        run(enc(8'h00, 8'h02, 8'h00, 8'h03), exp_pc + 4, "loadi_r2");
        run(enc(8'h03, 8'h03, 8'h01, 8'h02), exp_pc + 4, "sub");
        check("sub_pc12", PC, 32'd12);
        INSTRUCTION = enc(8'h11, 8'h00, 8'h03, 8'h3C);
        #1;
        check("swi_addr", MEM_ADDRESS, 8'h3C);
        check("swi_rd", MEM_READ, 0);
        read_reg(8'd3, 8'h02, "r3_sub");

        run(enc(8'h02, 8'h04, 8'h01, 8'h02), exp_pc + 4, "add");
        run(enc(8'h04, 8'h05, 8'h01, 8'h02), exp_pc + 4, "and");
        run(enc(8'h05, 8'h06, 8'h01, 8'h02), exp_pc + 4, "or");
        run(enc(8'h01, 8'h07, 8'h01, 8'h01), exp_pc + 4, "mov");
        read_reg(8'd4, 8'h08, "r4_add");
        read_reg(8'd5, 8'h01, "r5_and");
        read_reg(8'd6, 8'h07, "r6_or");
        read_reg(8'd7, 8'h05, "r7_mov");

        // wrap-around add/sub
        run(enc(8'h00, 8'h01, 8'h00, 8'hFF), exp_pc + 4, "loadi_ff");
        run(enc(8'h00, 8'h02, 8'h00, 8'h03), exp_pc + 4, "loadi_03");
        run(enc(8'h02, 8'h03, 8'h01, 8'h02), exp_pc + 4, "add_wrap");
        run(enc(8'h03, 8'h04, 8'h02, 8'h01), exp_pc + 4, "sub_wrap");
        read_reg(8'd3, 8'h02, "r3_addwrap");
        read_reg(8'd4, 8'h04, "r4_subwrap");

        // ---------------- shifts ----------------
        run(enc(8'h00, 8'h01, 8'h00, 8'h80), exp_pc + 4, "loadi_80");
        run(enc(8'h0C, 8'h02, 8'h01, 8'h09), exp_pc + 4, "sra9");
        run(enc(8'h0B, 8'h03, 8'h01, 8'h09), exp_pc + 4, "srl9");
        run(enc(8'h09, 8'h04, 8'h01, 8'h09), exp_pc + 4, "ror9");
        run(enc(8'h0A, 8'h05, 8'h01, 8'h01), exp_pc + 4, "sll1");
        run(enc(8'h0B, 8'h06, 8'h01, 8'h03), exp_pc + 4, "srl3");
        run(enc(8'h0C, 8'h07, 8'h01, 8'h03), exp_pc + 4, "sra3");
        run(enc(8'h09, 8'h00, 8'h01, 8'h08), exp_pc + 4, "ror8");
        read_reg(8'd2, 8'hFF, "r2_sra9");
        read_reg(8'd3, 8'h00, "r3_srl9");
        read_reg(8'd4, 8'h40, "r4_ror9");
        read_reg(8'd5, 8'h00, "r5_sll1");
        read_reg(8'd6, 8'h10, "r6_srl3");
        read_reg(8'd7, 8'hF0, "r7_sra3");
        read_reg(8'd0, 8'h80, "r0_ror8");

        // ---------------- undefined opcode ----------------
        run(enc(8'hFF, 8'h06, 8'h01, 8'h02), exp_pc + 4, "undef");
        read_reg(8'd6, 8'h10, "r6_undef");

        // ---------------- mult (optional) ----------------
        run(enc(8'h00, 8'h01, 8'h00, 8'h14), exp_pc + 4, "loadi_20");
        run(enc(8'h00, 8'h02, 8'h00, 8'h0D), exp_pc + 4, "loadi_13");
        run(enc(8'h00, 8'h03, 8'h00, 8'h77), exp_pc + 4, "loadi_77");
        run(enc(8'h0D, 8'h03, 8'h01, 8'h02), exp_pc + 4, "mult");
`ifdef CPU_STALL_MULT_EN
        read_reg(8'd3, 8'h04, "r3_mult");
`else
        read_reg(8'd3, 8'h77, "r3_mult");
`endif

        // ---------------- lwi with 3 stall cycles ----------------
        pc0          = exp_pc;
        INSTRUCTION  = enc(8'h0F, 8'h05, 8'h00, 8'h20);
        MEM_READDATA = 8'hA5;
        for (int c = 0; c < 5; c++) begin
            MEM_BUSYWAIT = (c >= 1 && c <= 3);
            #1;
            check($sformatf("lwi_rd_c%0d", c), MEM_READ, (c < 4) ? 1 : 0);
            check($sformatf("lwi_wr_c%0d", c), MEM_WRITE, 0);
            check($sformatf("lwi_addr_c%0d", c), MEM_ADDRESS, 8'h20);
            check($sformatf("lwi_pc_c%0d", c), PC, pc0);
            @(posedge CLK); #1;
        end
        MEM_BUSYWAIT = 1'b0;
        exp_pc = pc0 + 32'd4;
        check("lwi_pc_done", PC, exp_pc);
        read_reg(8'd5, 8'hA5, "r5_lwi");

        // ---------------- lwd, no stall (2 cycles) ----------------
        run(enc(8'h00, 8'h02, 8'h00, 8'h31), exp_pc + 4, "loadi_31");
        pc0          = exp_pc;
        INSTRUCTION  = enc(8'h0E, 8'h06, 8'h00, 8'h02);
        MEM_READDATA = 8'h3C;
        #1;
        check("lwd_rd", MEM_READ, 1);
        check("lwd_addr", MEM_ADDRESS, 8'h31);
        @(posedge CLK); #1;
        check("lwd_rd_done", MEM_READ, 0);
        check("lwd_pc_hold", PC, pc0);
        @(posedge CLK); #1;
        exp_pc = pc0 + 32'd4;
        check("lwd_pc", PC, exp_pc);
        read_reg(8'd6, 8'h3C, "r6_lwd");

        // ---------------- branches from PC=8 ----------------
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET  = 1'b0;
        exp_pc = 0;
        check("rst2_pc", PC, 0);
        run(enc(8'h00, 8'h01, 8'h00, 8'h01), exp_pc + 4, "b_loadi1");
        run(enc(8'h00, 8'h02, 8'h00, 8'h02), exp_pc + 4, "b_loadi2");
        run(enc(8'h08, 8'hFE, 8'h01, 8'h02), 32'd4,  "bne_taken");
        run(enc(8'hFF, 8'h00, 8'h00, 8'h00), 32'd8,  "nop");
        run(enc(8'h07, 8'hFE, 8'h01, 8'h02), 32'd12, "beq_nottaken");
        run(enc(8'h06, 8'h02, 8'h00, 8'h00), 32'd24, "j_fwd");
        run(enc(8'h07, 8'h01, 8'h01, 8'h01), 32'd32, "beq_taken");
        run(enc(8'h08, 8'h01, 8'h01, 8'h01), 32'd36, "bne_nottaken");
        run(enc(8'h06, 8'h80, 8'h00, 8'h00), 32'hFFFF_FE28, "j_wrap");

        // ---------------- swd, reset during MEM_WAIT ----------------
        pc0         = exp_pc;
        INSTRUCTION = enc(8'h10, 8'h00, 8'h01, 8'h02);
        #1;
        check("swd_wr", MEM_WRITE, 1);
        check("swd_addr", MEM_ADDRESS, 8'h02);
        check("swd_data", MEM_WRITEDATA, 8'h01);
        MEM_BUSYWAIT = 1'b1;
        @(posedge CLK); #1;
        check("swd_wr_wait", MEM_WRITE, 1);
        check("swd_pc_hold", PC, pc0);
        RESET = 1'b1;
        #1;
        check("swd_wr_rst", MEM_WRITE, 0);
        @(posedge CLK); #1;
        check("swd_rst_pc", PC, 0);
        check("swd_rst_wr", MEM_WRITE, 0);
        RESET        = 1'b0;
        MEM_BUSYWAIT = 1'b0;
        exp_pc       = 0;
        read_reg(8'd1, 8'h00, "r1_after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
